// File: rtl/audio_fader_pkg.sv
// Shared constants and types for the audio fader control block.
package audio_fader_pkg;

  localparam int unsigned GAIN_W_DEF = 16;

  localparam logic [1:0] REG_CTRL   = 2'd0;
  localparam logic [1:0] REG_TARGET = 2'd1;
  localparam logic [1:0] REG_STEP   = 2'd2;
  localparam logic [1:0] REG_STATUS = 2'd3;

  localparam int unsigned CTRL_EN   = 0;
  localparam int unsigned CTRL_MUTE = 1;
  localparam int unsigned CTRL_SNAP = 2;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RAMP = 1'b1
  } ramp_state_t;

endpackage

// File: rtl/audio_fader_ramp.sv
// Gain-ramp engine: steps the current gain toward the target on each sample tick.
module audio_fader_ramp
  import audio_fader_pkg::*;
#(
  parameter int unsigned GAIN_W = GAIN_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic              sample_tick,
  input  logic              snap,
  input  logic [GAIN_W-1:0] step,
  input  logic [GAIN_W-1:0] target,
  input  logic [GAIN_W-1:0] target_nxt,
  output logic [GAIN_W-1:0] current,
  output logic              busy,
  output logic              ramp_done
);

  ramp_state_t       state, state_nxt;
  logic [GAIN_W-1:0] cur_nxt;
  logic [GAIN_W:0]   sum_c;
  logic              done_nxt;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      current   <= '0;
      ramp_done <= 1'b0;
    end else begin
      state     <= state_nxt;
      current   <= cur_nxt;
      ramp_done <= done_nxt;
    end
  end

  // State tracks current != target using the values both take at the next edge.
  always_comb begin
    sum_c     = {1'b0, current} + {1'b0, step};
    cur_nxt   = current;
    done_nxt  = 1'b0;
    state_nxt = state;
    if (snap) begin
      cur_nxt = target;
    end else if (sample_tick && enable) begin
      if (current < target) begin
        cur_nxt = (sum_c > {1'b0, target}) ? target : sum_c[GAIN_W-1:0];
      end else if (current > target) begin
        cur_nxt = ((current - target) <= step) ? target : current - step;
      end
    end
    case (state)
      ST_RAMP: done_nxt = (cur_nxt == target);
      default: done_nxt = 1'b0;
    endcase
    state_nxt = (cur_nxt != target_nxt) ? ST_RAMP : ST_IDLE;
  end

  assign busy = (state == ST_RAMP);

endmodule

// File: rtl/audio_fader_ctrl_axil.sv
// AXI4-Lite register front end for the audio fader; drives the smoothed gain word.
module audio_fader_ctrl_axil
  import audio_fader_pkg::*;
#(
  parameter int unsigned C_S_AXI_DATA_WIDTH = 32,
  parameter int unsigned C_S_AXI_ADDR_WIDTH = 4,
  parameter int unsigned GAIN_W             = GAIN_W_DEF
) (
  input  logic                            s00_axi_aclk,
  input  logic                            s00_axi_areset,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s00_axi_awaddr,
  input  logic [2:0]                      s00_axi_awprot,
  input  logic                            s00_axi_awvalid,
  output logic                            s00_axi_awready,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   s00_axi_wdata,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0] s00_axi_wstrb,
  input  logic                            s00_axi_wvalid,
  output logic                            s00_axi_wready,
  output logic [1:0]                      s00_axi_bresp,
  output logic                            s00_axi_bvalid,
  input  logic                            s00_axi_bready,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s00_axi_araddr,
  input  logic [2:0]                      s00_axi_arprot,
  input  logic                            s00_axi_arvalid,
  output logic                            s00_axi_arready,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   s00_axi_rdata,
  output logic [1:0]                      s00_axi_rresp,
  output logic                            s00_axi_rvalid,
  input  logic                            s00_axi_rready,
  input  logic                            sample_tick,
  output logic [GAIN_W-1:0]               gain_o,
  output logic                            ramp_done_o
);

  localparam int unsigned DW = C_S_AXI_DATA_WIDTH;
  localparam int unsigned SW = C_S_AXI_DATA_WIDTH / 8;

  logic              aw_full, w_full, wr_en_c, snap_c;
  logic [1:0]        aw_idx;
  logic [DW-1:0]     wdata_q, rd_word_c;
  logic [SW-1:0]     wstrb_q;
  logic [1:0]        ctrl, ctrl_nxt;
  logic [GAIN_W-1:0] target, target_nxt, step, step_nxt, current;
  logic              busy;
  logic              unused;

  assign s00_axi_bresp = 2'b00;
  assign s00_axi_rresp = 2'b00;
  assign wr_en_c       = aw_full && w_full && !s00_axi_bvalid;
  assign unused = ^{s00_axi_awprot, s00_axi_arprot, s00_axi_awaddr[1:0],
                    s00_axi_araddr[1:0], wdata_q[DW-1:GAIN_W], wstrb_q[SW-1:GAIN_W/8]};

  // AW and W latch independently; no new address or data until B completes.
  always_ff @(posedge s00_axi_aclk) begin
    if (s00_axi_areset) begin
      s00_axi_awready <= 1'b0;
      s00_axi_wready  <= 1'b0;
      s00_axi_bvalid  <= 1'b0;
      aw_full         <= 1'b0;
      w_full          <= 1'b0;
      aw_idx          <= '0;
      wdata_q         <= '0;
      wstrb_q         <= '0;
    end else begin
      s00_axi_awready <= !s00_axi_awready && s00_axi_awvalid && !aw_full && !s00_axi_bvalid;
      s00_axi_wready  <= !s00_axi_wready && s00_axi_wvalid && !w_full && !s00_axi_bvalid;
      if (s00_axi_awready && s00_axi_awvalid) begin
        aw_full <= 1'b1;
        aw_idx  <= s00_axi_awaddr[3:2];
      end
      if (s00_axi_wready && s00_axi_wvalid) begin
        w_full  <= 1'b1;
        wdata_q <= s00_axi_wdata;
        wstrb_q <= s00_axi_wstrb;
      end
      if (wr_en_c) begin
        aw_full        <= 1'b0;
        w_full         <= 1'b0;
        s00_axi_bvalid <= 1'b1;
      end else if (s00_axi_bvalid && s00_axi_bready) begin
        s00_axi_bvalid <= 1'b0;
      end
    end
  end

  // Byte-lane register update; snap is a write-only pulse into the ramp.
  always_comb begin
    ctrl_nxt   = ctrl;
    target_nxt = target;
    step_nxt   = step;
    snap_c     = 1'b0;
    if (wr_en_c) begin
      case (aw_idx)
        REG_CTRL: begin
          if (wstrb_q[0]) begin
            ctrl_nxt = {wdata_q[CTRL_MUTE], wdata_q[CTRL_EN]};
            snap_c   = wdata_q[CTRL_SNAP];
          end
        end
        REG_TARGET: begin
          for (int b = 0; b < GAIN_W / 8; b++)
            if (wstrb_q[b]) target_nxt[8*b +: 8] = wdata_q[8*b +: 8];
        end
        REG_STEP: begin
          for (int b = 0; b < GAIN_W / 8; b++)
            if (wstrb_q[b]) step_nxt[8*b +: 8] = wdata_q[8*b +: 8];
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge s00_axi_aclk) begin
    if (s00_axi_areset) begin
      ctrl   <= '0;
      target <= '0;
      step   <= GAIN_W'(1);
      gain_o <= '0;
    end else begin
      ctrl   <= ctrl_nxt;
      target <= target_nxt;
      step   <= step_nxt;
      gain_o <= ctrl[CTRL_MUTE] ? '0 : current;
    end
  end

  always_comb begin
    rd_word_c = '0;
    case (s00_axi_araddr[3:2])
      REG_CTRL:   rd_word_c = DW'({ctrl[CTRL_MUTE], ctrl[CTRL_EN]});
      REG_TARGET: rd_word_c = DW'(target);
      REG_STEP:   rd_word_c = DW'(step);
      default:    rd_word_c = DW'({busy, current});
    endcase
  end

  // Read data is captured from the pre-edge registers, so a coincident write is not visible.
  always_ff @(posedge s00_axi_aclk) begin
    if (s00_axi_areset) begin
      s00_axi_arready <= 1'b0;
      s00_axi_rvalid  <= 1'b0;
      s00_axi_rdata   <= '0;
    end else begin
      s00_axi_arready <= !s00_axi_arready && s00_axi_arvalid && !s00_axi_rvalid;
      if (s00_axi_arready && s00_axi_arvalid) begin
        s00_axi_rvalid <= 1'b1;
        s00_axi_rdata  <= rd_word_c;
      end else if (s00_axi_rvalid && s00_axi_rready) begin
        s00_axi_rvalid <= 1'b0;
      end
    end
  end

  audio_fader_ramp #(.GAIN_W(GAIN_W)) u_ramp (
    .clk        (s00_axi_aclk),
    .rst        (s00_axi_areset),
    .enable     (ctrl[CTRL_EN]),
    .sample_tick(sample_tick),
    .snap       (snap_c),
    .step       (step),
    .target     (target),
    .target_nxt (target_nxt),
    .current    (current),
    .busy       (busy),
    .ramp_done  (ramp_done_o)
  );

endmodule

// File: tb/tb_audio_fader_ctrl_axil.sv
// Self-checking bench for audio_fader_ctrl_axil with read-data and gain scoreboards.
module tb_audio_fader_ctrl_axil;

  logic        clk;
  logic        areset;
  logic [3:0]  awaddr, araddr;
  logic [2:0]  awprot, arprot;
  logic        awvalid, awready, wvalid, wready, bvalid, bready;
  logic        arvalid, arready, rvalid, rready;
  logic [31:0] wdata, rdata;
  logic [3:0]  wstrb;
  logic [1:0]  bresp, rresp;
  logic        sample_tick;
  logic [15:0] gain_o;
  logic        ramp_done_o;

  int vectors;
  int miscompares;
  int done_cnt;
  logic [31:0] rd_q[$];
  logic [15:0] gain_q[$];

  audio_fader_ctrl_axil dut (
    .s00_axi_aclk   (clk),
    .s00_axi_areset (areset),
    .s00_axi_awaddr (awaddr),
    .s00_axi_awprot (awprot),
    .s00_axi_awvalid(awvalid),
    .s00_axi_awready(awready),
    .s00_axi_wdata  (wdata),
    .s00_axi_wstrb  (wstrb),
    .s00_axi_wvalid (wvalid),
    .s00_axi_wready (wready),
    .s00_axi_bresp  (bresp),
    .s00_axi_bvalid (bvalid),
    .s00_axi_bready (bready),
    .s00_axi_araddr (araddr),
    .s00_axi_arprot (arprot),
    .s00_axi_arvalid(arvalid),
    .s00_axi_arready(arready),
    .s00_axi_rdata  (rdata),
    .s00_axi_rresp  (rresp),
    .s00_axi_rvalid (rvalid),
    .s00_axi_rready (rready),
    .sample_tick    (sample_tick),
    .gain_o         (gain_o),
    .ramp_done_o    (ramp_done_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (areset) done_cnt <= 0;
    else if (ramp_done_o === 1'b1) done_cnt <= done_cnt + 1;
  end

  task automatic axi_write(input logic [3:0] addr, input logic [31:0] data, input logic [3:0] strb);
    logic aw_hs, w_hs;
    bit aw_done, w_done, b_done;
    aw_done = 0; w_done = 0; b_done = 0;
    awaddr = addr; wdata = data; wstrb = strb; awvalid = 1'b1; wvalid = 1'b1;
    for (int i = 0; i < 20 && !(aw_done && w_done); i++) begin
      aw_hs = awready && awvalid;
      w_hs  = wready && wvalid;
      @(posedge clk); #1;
      if (aw_hs) begin awvalid = 1'b0; aw_done = 1; end
      if (w_hs)  begin wvalid = 1'b0;  w_done = 1;  end
    end
    awvalid = 1'b0; wvalid = 1'b0;
    for (int i = 0; i < 20 && !b_done; i++) begin
      if (bvalid) b_done = 1;
      else begin @(posedge clk); #1; end
    end
    vectors++;
    if (!(aw_done && w_done && b_done)) begin
      miscompares++;
      $display("FAIL write_handshake addr=%h: aw=%0d w=%0d b=%0d, want all 1", addr, aw_done, w_done, b_done);
    end else begin
      vectors++;
      if (bresp !== 2'b00) begin
        miscompares++;
        $display("FAIL bresp addr=%h: got %b want 00", addr, bresp);
      end
      bready = 1'b1;
      @(posedge clk); #1;
      bready = 1'b0;
    end
  endtask

  task automatic axi_read(input logic [3:0] addr, input logic [31:0] exp);
    logic hs;
    bit ok;
    logic [31:0] e;
    rd_q.push_back(exp);
    araddr = addr; arvalid = 1'b1; ok = 0;
    for (int i = 0; i < 20 && !ok; i++) begin
      hs = arready && arvalid;
      @(posedge clk); #1;
      if (hs) ok = 1;
    end
    arvalid = 1'b0;
    if (ok) begin
      ok = 0;
      for (int i = 0; i < 20 && !ok; i++) begin
        if (rvalid) ok = 1;
        else begin @(posedge clk); #1; end
      end
    end
    e = rd_q.pop_front();
    vectors++;
    if (!ok) begin
      miscompares++;
      $display("FAIL read_handshake addr=%h: no rvalid within bound", addr);
    end else begin
      if (rdata !== e || rresp !== 2'b00) begin
        miscompares++;
        $display("FAIL read addr=%h: got %h/%b want %h/00", addr, rdata, rresp, e);
      end
      rready = 1'b1;
      @(posedge clk); #1;
      rready = 1'b0;
    end
  endtask

  task automatic do_tick(input logic [15:0] exp);
    logic [15:0] e;
    gain_q.push_back(exp);
    sample_tick = 1'b1;
    @(posedge clk); #1;
    sample_tick = 1'b0;
    @(posedge clk); #1;
    e = gain_q.pop_front();
    vectors++;
    if (gain_o !== e) begin
      miscompares++;
      $display("FAIL tick_gain: got %h want %h", gain_o, e);
    end
  endtask

  task automatic check_gain(input logic [15:0] exp);
    logic [15:0] e;
    gain_q.push_back(exp);
    e = gain_q.pop_front();
    vectors++;
    if (gain_o !== e) begin
      miscompares++;
      $display("FAIL gain_now: got %h want %h", gain_o, e);
    end
  endtask

  task automatic check_done(input int base, input int delta);
    vectors++;
    if (done_cnt - base != delta) begin
      miscompares++;
      $display("FAIL ramp_done_count: got %0d want %0d", done_cnt - base, delta);
    end
  endtask

  task automatic test_reset();
    areset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    vectors++;
    if ({awready, wready, bvalid, arready, rvalid} !== 5'b0 || rdata !== 32'h0) begin
      miscompares++;
      $display("FAIL reset_axi: got rdy/vld %b rdata %h want 00000/0", {awready, wready, bvalid, arready, rvalid}, rdata);
    end
    vectors++;
    if (gain_o !== 16'h0 || ramp_done_o !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_out: got gain %h done %b want 0000/0", gain_o, ramp_done_o);
    end
    areset = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_regs();
    axi_write(4'h0, 32'h1, 4'hF);
    axi_write(4'h4, 32'h2, 4'hF);
    axi_write(4'h8, 32'h3, 4'hF);
    axi_write(4'hC, 32'h4, 4'hF);
    axi_read(4'h0, 32'h1);
    axi_read(4'h4, 32'h2);
    axi_read(4'h8, 32'h3);
    axi_read(4'hC, 32'h0001_0000);
  endtask

  task automatic test_ramp_up();
    int d0;
    axi_write(4'h4, 32'h0100, 4'hF);
    axi_write(4'h8, 32'h0040, 4'hF);
    axi_write(4'h0, 32'h1, 4'hF);
    d0 = done_cnt;
    do_tick(16'h0040);
    do_tick(16'h0080);
    do_tick(16'h00C0);
    do_tick(16'h0100);
    check_done(d0, 1);
    axi_read(4'hC, 32'h0000_0100);
  endtask

  task automatic test_ramp_down_sat();
    int d0;
    d0 = done_cnt;
    axi_write(4'h4, 32'h0050, 4'hF);
    axi_write(4'h8, 32'h0030, 4'hF);
    do_tick(16'h00D0);
    do_tick(16'h00A0);
    do_tick(16'h0070);
    do_tick(16'h0050);
    axi_write(4'h8, 32'hFFFF, 4'hF);
    axi_write(4'h4, 32'hFFF0, 4'hF);
    do_tick(16'hFFF0);
    axi_write(4'h4, 32'hFFFF, 4'hF);
    do_tick(16'hFFFF);
    do_tick(16'hFFFF);
    check_done(d0, 3);
    axi_write(4'h8, 32'h0, 4'hF);
    axi_write(4'h4, 32'h0, 4'hF);
    do_tick(16'hFFFF);
    axi_read(4'hC, 32'h0001_FFFF);
    axi_write(4'h4, 32'hABCD, 4'h1);
    axi_read(4'h4, 32'h0000_00CD);
    axi_write(4'h4, 32'h1200, 4'h2);
    axi_read(4'h4, 32'h0000_12CD);
  endtask

  task automatic test_aw_before_w();
    logic hs;
    bit ok;
    awaddr = 4'h4; awvalid = 1'b1; ok = 0;
    for (int i = 0; i < 20 && !ok; i++) begin
      hs = awready && awvalid;
      @(posedge clk); #1;
      if (hs) ok = 1;
    end
    vectors++;
    if (!ok) begin
      miscompares++;
      $display("FAIL aw_only_accept: got no awready want accept");
    end
    awaddr = 4'h8;
    for (int i = 0; i < 5; i++) begin
      vectors++;
      if (awready !== 1'b0 || bvalid !== 1'b0) begin
        miscompares++;
        $display("FAIL aw_wait cycle %0d: got awready %b bvalid %b want 0/0", i, awready, bvalid);
      end
      @(posedge clk); #1;
    end
    axi_read(4'h4, 32'h0000_12CD);
    wdata = 32'h1234; wstrb = 4'hF; wvalid = 1'b1; ok = 0;
    for (int i = 0; i < 20 && !ok; i++) begin
      hs = wready && wvalid;
      @(posedge clk); #1;
      if (hs) ok = 1;
    end
    wvalid = 1'b0; ok = 0;
    for (int i = 0; i < 20 && !ok; i++) begin
      if (bvalid) ok = 1;
      else begin @(posedge clk); #1; end
    end
    vectors++;
    if (!ok) begin
      miscompares++;
      $display("FAIL late_w_bvalid: got no bvalid want bvalid");
    end
    for (int i = 0; i < 3; i++) begin
      vectors++;
      if (bvalid !== 1'b1 || awready !== 1'b0) begin
        miscompares++;
        $display("FAIL b_hold cycle %0d: got bvalid %b awready %b want 1/0", i, bvalid, awready);
      end
      @(posedge clk); #1;
    end
    awvalid = 1'b0;
    bready = 1'b1;
    @(posedge clk); #1;
    bready = 1'b0;
    vectors++;
    if (bvalid !== 1'b0) begin
      miscompares++;
      $display("FAIL b_release: got bvalid %b want 0", bvalid);
    end
    axi_read(4'h4, 32'h0000_1234);
  endtask

  task automatic test_back_to_back();
    fork
      axi_write(4'h4, 32'h0777, 4'hF);
      begin
        @(posedge clk); #1;
        axi_read(4'h4, 32'h0000_1234);
      end
    join
    axi_read(4'h4, 32'h0000_0777);
  endtask

  task automatic test_mute_snap();
    int d0;
    axi_write(4'h8, 32'h0100, 4'hF);
    axi_write(4'h4, 32'hFC00, 4'hF);
    axi_write(4'h0, 32'h3, 4'hF);
    do_tick(16'h0000);
    axi_read(4'hC, 32'h0001_FEFF);
    do_tick(16'h0000);
    axi_write(4'h0, 32'h1, 4'hF);
    check_gain(16'hFDFF);
    d0 = done_cnt;
    axi_write(4'h0, 32'h5, 4'hF);
    check_gain(16'hFC00);
    check_done(d0, 1);
    axi_read(4'h0, 32'h0000_0001);
    axi_read(4'hC, 32'h0000_FC00);
    axi_write(4'h0, 32'h0, 4'hF);
    axi_write(4'h4, 32'h0100, 4'hF);
    do_tick(16'hFC00);
    axi_read(4'hC, 32'h0001_FC00);
  endtask

  task automatic test_reset_mid();
    logic hs;
    bit ok;
    araddr = 4'h8; arvalid = 1'b1; ok = 0;
    for (int i = 0; i < 20 && !ok; i++) begin
      hs = arready && arvalid;
      @(posedge clk); #1;
      if (hs) ok = 1;
    end
    arvalid = 1'b0;
    vectors++;
    if (rvalid !== 1'b1) begin
      miscompares++;
      $display("FAIL pre_reset_rvalid: got %b want 1", rvalid);
    end
    areset = 1'b1;
    @(posedge clk); #1;
    vectors++;
    if (rvalid !== 1'b0 || gain_o !== 16'h0 || bvalid !== 1'b0 || arready !== 1'b0) begin
      miscompares++;
      $display("FAIL mid_reset: got rvalid %b gain %h bvalid %b arready %b want 0/0000/0/0", rvalid, gain_o, bvalid, arready);
    end
    areset = 1'b0;
    @(posedge clk); #1;
    axi_read(4'h0, 32'h0);
    axi_read(4'h4, 32'h0);
    axi_read(4'h8, 32'h1);
    axi_read(4'hC, 32'h0);
  endtask

  initial begin
    vectors = 0; miscompares = 0;
    areset = 1'b1;
    awaddr = '0; araddr = '0; awprot = '0; arprot = '0;
    awvalid = 1'b0; wvalid = 1'b0; bready = 1'b0; arvalid = 1'b0; rready = 1'b0;
    wdata = '0; wstrb = '0; sample_tick = 1'b0;
    test_reset();
    test_regs();
    test_ramp_up();
    test_ramp_down_sat();
    test_aw_before_w();
    test_back_to_back();
    test_mute_snap();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
